// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of an async divided clock in clk cycles, checks period vs exp_period.
// Latency: results and meas_valid appear two clk edges after the edge that first samples a div_in rise.
// No backpressure: each measurement overwrites the last. `define DIV_MON_DUTY_CHECK_EN adds a ~50% duty requirement.
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   TOL_V   = TOL[CNT_W:0];
    localparam logic [3:0]       LOCK_V  = LOCK_CNT[3:0];

    state_t           state, state_nxt;
    logic             s0, s1, s2;
    logic             rise;
    logic [CNT_W-1:0] per_cnt, per_cnt_nxt;
    logic [CNT_W-1:0] hi_cnt, hi_cnt_nxt;
    logic [CNT_W-1:0] period_nxt, high_cnt_nxt;
    logic [3:0]       run, run_nxt;
    logic             meas_valid_nxt, err_nxt;
    logic [CNT_W:0]   per_diff;
    logic             per_ok, match, timeout;

    assign rise    = s1 & ~s2;
    assign timeout = (per_cnt == CNT_MAX);
    assign locked  = (state == LOCKED);

    assign per_diff = (per_cnt >= exp_period) ? ({1'b0, per_cnt} - {1'b0, exp_period})
                                              : ({1'b0, exp_period} - {1'b0, per_cnt});
    // A zero expected period is treated as "never lock", whatever the tolerance.
    assign per_ok = (exp_period != '0) && (per_diff <= TOL_V);

`ifdef DIV_MON_DUTY_CHECK_EN
    logic [CNT_W+1:0] two_hi, per_x, duty_diff;
    assign two_hi    = {1'b0, hi_cnt, 1'b0};
    assign per_x     = {2'b00, per_cnt};
    assign duty_diff = (two_hi >= per_x) ? (two_hi - per_x) : (per_x - two_hi);
    assign match     = per_ok && (duty_diff <= {{(CNT_W+1){1'b0}}, 1'b1});
`else
    assign match = per_ok;
`endif

    always_comb begin
        state_nxt      = state;
        per_cnt_nxt    = per_cnt;
        hi_cnt_nxt     = hi_cnt;
        period_nxt     = period;
        high_cnt_nxt   = high_cnt;
        meas_valid_nxt = 1'b0;
        run_nxt        = run;
        err_nxt        = err;

        // ARM keeps the counters parked so the partial first period is never measured.
        if (state == IDLE) begin
            per_cnt_nxt = '0;
            hi_cnt_nxt  = '0;
        end else if (rise) begin
            per_cnt_nxt = ONE;
            hi_cnt_nxt  = {{(CNT_W-1){1'b0}}, s1};
        end else if (state == ARM) begin
            per_cnt_nxt = '0;
            hi_cnt_nxt  = '0;
        end else begin
            if (per_cnt != CNT_MAX) per_cnt_nxt = per_cnt + ONE;
            if (hi_cnt != CNT_MAX)  hi_cnt_nxt  = hi_cnt + {{(CNT_W-1){1'b0}}, s1};
        end

        case (state)
            IDLE: begin
                if (en) state_nxt = ARM;
            end
            ARM: begin
                if (rise) state_nxt = MEAS;
            end
            MEAS, LOCKED: begin
                if (rise) begin
                    period_nxt     = per_cnt;
                    high_cnt_nxt   = hi_cnt;
                    meas_valid_nxt = 1'b1;
                    if (match) begin
                        run_nxt = (run >= LOCK_V) ? LOCK_V : run + 4'd1;
                        if (run_nxt == LOCK_V) state_nxt = LOCKED;
                    end else begin
                        run_nxt = '0;
                        if (state == LOCKED) begin
                            state_nxt = MEAS;
                            err_nxt   = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    state_nxt = ARM;
                    err_nxt   = 1'b1;
                    run_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!en) begin
            state_nxt      = IDLE;
            per_cnt_nxt    = '0;
            hi_cnt_nxt     = '0;
            period_nxt     = '0;
            high_cnt_nxt   = '0;
            meas_valid_nxt = 1'b0;
            run_nxt        = '0;
            err_nxt        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0         <= 1'b0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            run        <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            s0         <= div_in;
            s1         <= s0;
            s2         <= s1;
            state      <= state_nxt;
            per_cnt    <= per_cnt_nxt;
            hi_cnt     <= hi_cnt_nxt;
            run        <= run_nxt;
            period     <= period_nxt;
            high_cnt   <= high_cnt_nxt;
            meas_valid <= meas_valid_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Downstream checker for the clock-divider outputs, e.g. the 50%-duty divide-by-3 clock.
- Samples a divided clock in the reference clock domain and measures its period and high time in reference cycles.
- Compares the period against a programmed expected value and raises lock and error status.
- Used in bring-up and self-test to confirm that each divider stage produces the intended frequency.

Parameters:
CNT_W, 8, width of the period/high-time counters and results
LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15)
TOL, 0, allowed |period - exp_period| still counted as a match

Ports:
clk  input  1  reference clock, the same clock that feeds the divider
rst  input  1  asynchronous, active-low reset
en  input  1  monitor enable; low forces IDLE and clears status
div_in  input  1  divided clock under test, treated as asynchronous
exp_period  input  CNT_W  expected period in clk cycles; sampled on every measurement
period  output  CNT_W  last measured period, in clk cycles
high_cnt  output  CNT_W  clk cycles with div_in high during the last period
meas_valid  output  1  one-cycle pulse when period/high_cnt update
locked  output  1  LOCK_CNT consecutive matches seen and no mismatch since
err  output  1  sticky: mismatch after lock, or timeout; cleared only by en=0 or reset

Behaviour:
- Reset (rst=0, asynchronous): all flops clear. FSM=IDLE; period=0, high_cnt=0, meas_valid=0, locked=0, err=0.
- Synchronizer and edge detect:
  - div_in passes through a 2-flop synchronizer (s0, s1), then a delay flop s2.
  - rise = s1 & ~s2. A div_in rising edge sampled at posedge N gives rise high in the cycle after posedge N+1.
- Counters:
  - per_cnt loads 1 on rise, otherwise increments, saturating at 2^CNT_W-1.
  - hi_cnt loads s1 on rise, otherwise adds s1, saturating.
- FSM states: IDLE, ARM, MEAS, LOCKED.
  - IDLE: counters held at 0. en=1 -> ARM.
  - ARM: discards the partial first period. First rise -> MEAS; counters start on that rise.
  - MEAS: each rise, at the next posedge:
    - period <= per_cnt; high_cnt <= hi_cnt; meas_valid=1 for one cycle.
    - match = |per_cnt - exp_period| <= TOL, computed unsigned with CNT_W+1-bit difference.
    - match increments run (saturating at LOCK_CNT); a mismatch clears run.
    - When run reaches LOCK_CNT -> LOCKED, locked=1 in the same cycle as that meas_valid.
  - LOCKED: measurements continue as in MEAS.
    - Mismatch -> MEAS, locked=0, err=1, run=0; all in the same cycle as that meas_valid.
- Timeout: in MEAS or LOCKED, per_cnt reaching saturation -> ARM, locked=0, err=1, run=0, with no meas_valid. Timeout in ARM is ignored.
- en=0, any state: next cycle -> IDLE. locked, err, run, meas_valid cleared; period and high_cnt cleared to 0.
- Simultaneous rise and timeout in the same cycle: the rise wins and is measured normally (per_cnt is saturated, so the value is reported).
- exp_period=0: never matches; locked never asserts.
- exp_period changed mid-run takes effect at the next rise; no other side effect.
- Reset mid-measurement: immediate clear, as under Reset; the next measurement requires en and a fresh ARM.

Optional Feature:
- Macro: DIV_MON_DUTY_CHECK_EN.
- Defined: match additionally requires |2*hi_cnt - per_cnt| <= 1, i.e. 50% duty within one sample, which accepts odd divisors. Any duty failure counts as a mismatch for run, locked and err.
- Undefined: match is period-only; high_cnt is still reported.

Test Plan:
1. Reset then en=1, div_in toggled high 2 / low 1 cycles repeatedly, exp_period=3, LOCK_CNT=4 -> meas_valid every 3 cycles, period=3, high_cnt=2, locked=1 on the 4th meas_valid, err=0.
2. Locked on period 3, then one period stretched to 4 -> that meas_valid shows period=4, locked=0, err=1. Subsequent 3-cycle periods relock after 4 matches; err stays 1 until en=0.
3. TOL=1, exp_period=6, periods alternating 5/7 -> all match, locked after 4 measurements.
4. Locked, then div_in held low, CNT_W=4 -> after 15 cycles without rise: locked=0, err=1, FSM in ARM, no meas_valid. Restart toggling -> first full period measured only after a fresh rise.
5. en dropped for 1 cycle while LOCKED -> next cycle locked=0, err=0, period=0. With en=1 again, the first partial period is not reported.
6. With DIV_MON_DUTY_CHECK_EN: high 1 / low 2 at exp_period=3 matches (|2-3|<=1); high 1 / low 3 at exp_period=4 fails (|2-4|=2), so locked never asserts.
